// File: rtl/morse_tx_sequencer.sv
// Morse code transmitter: queues ASCII characters in a small FIFO and keys them
// onto a registered on/off line using standard international Morse timing.
module morse_tx_sequencer #(
   parameter int UNIT_CYCLES = 1,
   parameter int DEPTH       = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       signal_out,
   output logic       busy,
   output logic       char_err,
   output logic       char_done
);

   localparam int TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_CYCLES - 1);
   localparam logic [TW-1:0] TICK_PEN  = (UNIT_CYCLES > 1) ? TW'(UNIT_CYCLES - 2) : '0;
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MARK,
      ELEM_GAP,
      LETTER_GAP,
      WORD_GAP
   } state_t;

   typedef struct packed {
      logic       ok;
      logic       space;
      logic [2:0] len;
      logic [3:0] pat;
   } code_t;

   function automatic code_t letter(input logic [2:0] len, input logic [3:0] pat);
      code_t r;
      r.ok    = 1'b1;
      r.space = 1'b0;
      r.len   = len;
      r.pat   = pat;
      return r;
   endfunction

   // Patterns are MSB-aligned: the first element sits in bit 3, 1 = dash.
   function automatic code_t morse_lookup(input logic [7:0] c);
      logic [7:0] up;
      code_t      r;
      up = c;
      if (c >= 8'h61 && c <= 8'h7A) begin
         up = c - 8'h20;
      end
      r = '0;
      case (up)
         8'h20: begin
            r.ok    = 1'b1;
            r.space = 1'b1;
         end
         8'h41: r = letter(3'd2, 4'b0100);
         8'h42: r = letter(3'd4, 4'b1000);
         8'h43: r = letter(3'd4, 4'b1010);
         8'h44: r = letter(3'd3, 4'b1000);
         8'h45: r = letter(3'd1, 4'b0000);
         8'h46: r = letter(3'd4, 4'b0010);
         8'h47: r = letter(3'd3, 4'b1100);
         8'h48: r = letter(3'd4, 4'b0000);
         8'h49: r = letter(3'd2, 4'b0000);
         8'h4A: r = letter(3'd4, 4'b0111);
         8'h4B: r = letter(3'd3, 4'b1010);
         8'h4C: r = letter(3'd4, 4'b0100);
         8'h4D: r = letter(3'd2, 4'b1100);
         8'h4E: r = letter(3'd2, 4'b1000);
         8'h4F: r = letter(3'd3, 4'b1110);
         8'h50: r = letter(3'd4, 4'b0110);
         8'h51: r = letter(3'd4, 4'b1101);
         8'h52: r = letter(3'd3, 4'b0100);
         8'h53: r = letter(3'd3, 4'b0000);
         8'h54: r = letter(3'd1, 4'b1000);
         8'h55: r = letter(3'd3, 4'b0010);
         8'h56: r = letter(3'd4, 4'b0001);
         8'h57: r = letter(3'd3, 4'b0110);
         8'h58: r = letter(3'd4, 4'b1001);
         8'h59: r = letter(3'd4, 4'b1011);
         8'h5A: r = letter(3'd4, 4'b1100);
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   state_t        state;
   logic [TW-1:0] tick;
   logic [1:0]    unit;
   logic [1:0]    unit_last;
   logic          tick_wrap;
   logic          state_end;
   logic          in_gap;
   logic          gap_pen;

   logic [7:0]    cur_char;
   logic [3:0]    pat;
   logic [2:0]    elem_left;
   code_t         code;

   assign char_ready = (count != FULL_CNT);
   assign push       = char_valid && char_ready;
   assign busy       = (state != IDLE) || (count != '0);
   assign code       = morse_lookup(cur_char);

   always_comb begin
      unit_last = 2'd0;
      case (state)
         MARK:       unit_last = pat[3] ? 2'd2 : 2'd0;
         LETTER_GAP: unit_last = 2'd2;
         WORD_GAP:   unit_last = 2'd3;
         default:    unit_last = 2'd0;
      endcase
   end

   assign tick_wrap = (tick == TICK_LAST);
   assign state_end = tick_wrap && (unit == unit_last);
   assign in_gap    = (state == LETTER_GAP) || (state == WORD_GAP);
   // Gaps last at least 3 units, so the cycle before the final one is always inside the gap.
   assign gap_pen   = in_gap && ((UNIT_CYCLES == 1) ? (unit == unit_last - 2'd1)
                                                     : (tick == TICK_PEN && unit == unit_last));
   assign pop       = (count != '0) && ((state == IDLE) || (in_gap && state_end));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= char_in;
      if (pop)  cur_char <= mem[rd_ptr];
      if (state == LOAD) begin
         pat       <= code.pat;
         elem_left <= code.len;
      end else if (state == ELEM_GAP && state_end) begin
         pat       <= {pat[2:0], 1'b0};
         elem_left <= elem_left - 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         tick       <= '0;
         unit       <= '0;
         signal_out <= 1'b0;
         char_err   <= 1'b0;
         char_done  <= 1'b0;
      end else begin
         char_err  <= 1'b0;
         char_done <= gap_pen;
         if (tick_wrap) begin
            tick <= '0;
            unit <= unit + 2'd1;
         end else begin
            tick <= tick + TW'(1);
         end
         case (state)
            IDLE: begin
               signal_out <= 1'b0;
               if (pop) begin
                  state <= LOAD;
                  tick  <= '0;
                  unit  <= '0;
               end
            end
            LOAD: begin
               tick <= '0;
               unit <= '0;
               if (code.ok && !code.space) begin
                  state      <= MARK;
                  signal_out <= 1'b1;
               end else if (code.ok) begin
                  state <= WORD_GAP;
               end else begin
                  state    <= IDLE;
                  char_err <= 1'b1;
               end
            end
            MARK: begin
               if (state_end) begin
                  tick       <= '0;
                  unit       <= '0;
                  signal_out <= 1'b0;
                  state      <= (elem_left > 3'd1) ? ELEM_GAP : LETTER_GAP;
               end
            end
            ELEM_GAP: begin
               if (state_end) begin
                  tick       <= '0;
                  unit       <= '0;
                  signal_out <= 1'b1;
                  state      <= MARK;
               end
            end
            LETTER_GAP, WORD_GAP: begin
               if (state_end) begin
                  tick  <= '0;
                  unit  <= '0;
                  state <= pop ? LOAD : IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               signal_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Bench for morse_tx_sequencer: a unit-1 and a unit-3 instance share stimulus;
// the selected one is compared every cycle against a waveform-expansion model.
module tb_morse_tx_sequencer;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;

   logic r1, s1, b1, e1, d1;
   logic r3, s3, b3, e3, d3;

   morse_tx_sequencer #(.UNIT_CYCLES(1), .DEPTH(DEPTH)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
      .char_ready(r1), .signal_out(s1), .busy(b1), .char_err(e1), .char_done(d1));

   morse_tx_sequencer #(.UNIT_CYCLES(3), .DEPTH(DEPTH)) u_dut3 (
      .clock(clock), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
      .char_ready(r3), .signal_out(s3), .busy(b3), .char_err(e3), .char_done(d3));

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int sel_unit = 1;

   string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                             ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                             "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

   typedef struct packed {
      logic sig;
      logic done;
      logic last;
      logic bad;
   } ent_t;

   ent_t       wave [$];
   logic [7:0] fifo_m [$];
   logic       err_now = 1'b0;
   logic       pushed = 1'b0;

   task automatic add_ent(input int n, input logic s);
      ent_t e;
      e = '0;
      e.sig = s;
      for (int i = 0; i < n; i++) wave.push_back(e);
   endtask

   task automatic mark_last();
      ent_t e;
      e = wave[wave.size() - 1];
      e.done = 1'b1;
      e.last = 1'b1;
      wave[wave.size() - 1] = e;
   endtask

   // One LOAD cycle, then the character's on/off units stretched by the unit length.
   task automatic expand(input logic [7:0] c);
      logic [7:0] up;
      string      code;
      ent_t       e;
      int         u;
      u = sel_unit;
      up = c;
      if (c >= 8'h61 && c <= 8'h7A) up = c - 8'd32;
      e = '0;
      if (up >= 8'h41 && up <= 8'h5A) begin
         wave.push_back(e);
         code = morse_tab[up - 8'h41];
         for (int i = 0; i < code.len(); i++) begin
            add_ent((code[i] == 8'h2D) ? 3 * u : u, 1'b1);
            if (i < code.len() - 1) add_ent(u, 1'b0);
         end
         add_ent(3 * u, 1'b0);
         mark_last();
      end else if (up == 8'h20) begin
         wave.push_back(e);
         add_ent(4 * u, 1'b0);
         mark_last();
      end else begin
         e.bad = 1'b1;
         wave.push_back(e);
      end
   endtask

   task automatic model_step();
      ent_t e;
      logic pop_ok;
      logic ready_before;
      pushed = 1'b0;
      err_now = 1'b0;
      if (!reset_n) begin
         wave.delete();
         fifo_m.delete();
         return;
      end
      pop_ok = (wave.size() == 0);
      if (!pop_ok) begin
         e = wave.pop_front();
         if (e.last) pop_ok = 1'b1;
         if (e.bad) err_now = 1'b1;
      end
      ready_before = (fifo_m.size() < DEPTH);
      if (pop_ok && fifo_m.size() > 0) expand(fifo_m.pop_front());
      if (char_valid && ready_before) begin
         fifo_m.push_back(char_in);
         pushed = 1'b1;
      end
   endtask

   function automatic logic [4:0] expv();
      logic s;
      logic d;
      s = 1'b0;
      d = 1'b0;
      if (wave.size() > 0) begin
         s = wave[0].sig;
         d = wave[0].done;
      end
      return {s, d, err_now, (wave.size() > 0) || (fifo_m.size() > 0), fifo_m.size() < DEPTH};
   endfunction

   function automatic logic [4:0] obs();
      return (sel_unit == 3) ? {s3, d3, e3, b3, r3} : {s1, d1, e1, b1, r1};
   endfunction

   function automatic logic model_idle();
      return (wave.size() == 0) && (fifo_m.size() == 0);
   endfunction

   task automatic step();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      vectors++;
      if ({s1, d1, e1, b1, r1} !== 5'b00001) begin
         miscompares++;
         $display("FAIL reset_async_u1: got %b want 00001 (sig,done,err,busy,ready)", {s1, d1, e1, b1, r1});
      end
      vectors++;
      if ({s3, d3, e3, b3, r3} !== 5'b00001) begin
         miscompares++;
         $display("FAIL reset_async_u3: got %b want 00001", {s3, d3, e3, b3, r3});
      end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) reset_n = 1'b1;
         step();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_idle cyc%0d: got %b want %b", i, obs(), expv());
         end
      end
   endtask

   task automatic test_latency();
      string line;
      string dn;
      line = "";
      dn = "";
      for (int i = 0; i < 14; i++) begin
         char_valid = (i == 0);
         char_in = "N";
         step();
         char_valid = 1'b0;
         if (i < 10) begin
            line = {line, s1 ? "1" : "0"};
            dn = {dn, d1 ? "1" : "0"};
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL latency_N cyc%0d: got %b want %b", i, obs(), expv());
         end
      end
      vectors++;
      if (line != "0011101000") begin
         miscompares++;
         $display("FAIL latency_N_line: got %s want 0011101000", line);
      end
      vectors++;
      if (dn != "0000000001") begin
         miscompares++;
         $display("FAIL latency_N_done: got %s want 0000000001", dn);
      end
      vectors++;
      if (b1 !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_N_busy_fall: got %b want 0", b1);
      end
   endtask

   task automatic test_word_gap();
      string s;
      string line;
      int    k;
      logic  ok;
      s = "O P";
      line = "";
      k = 0;
      ok = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         char_valid = (k < s.len());
         if (k < s.len()) char_in = s[k];
         step();
         if (pushed) k++;
         if (cyc < 36) line = {line, s1 ? "1" : "0"};
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL word_gap cyc%0d: got %b want %b", cyc, obs(), expv());
         end
         if (k == s.len() && model_idle()) begin
            ok = 1'b1;
            break;
         end
      end
      char_valid = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL word_gap_timeout: busy=%b want drained", b1);
      end
      vectors++;
      if (line != "001110111011100000000010111011101000") begin
         miscompares++;
         $display("FAIL word_gap_line: got %s want 001110111011100000000010111011101000", line);
      end
   endtask

   task automatic test_fifo_full();
      int   k;
      int   dones;
      logic saw_full;
      logic ok;
      k = 0;
      dones = 0;
      saw_full = 1'b0;
      ok = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         char_valid = (k < 6);
         char_in = "E";
         step();
         if (pushed) k++;
         if (!r1) saw_full = 1'b1;
         if (d1) dones++;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL fifo_full cyc%0d: got %b want %b", cyc, obs(), expv());
         end
         if (k == 6 && model_idle()) begin
            ok = 1'b1;
            break;
         end
      end
      char_valid = 1'b0;
      vectors++;
      if (!ok || !saw_full) begin
         miscompares++;
         $display("FAIL fifo_full_seen: drained=%b full_seen=%b want 1 1", ok, saw_full);
      end
      vectors++;
      if (dones != 6) begin
         miscompares++;
         $display("FAIL fifo_full_dones: got %0d want 6", dones);
      end
   endtask

   task automatic test_unsupported();
      string s;
      string line;
      string er;
      int    k;
      s = "#A";
      line = "";
      er = "";
      k = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         char_valid = (k < s.len());
         if (k < s.len()) char_in = s[k];
         step();
         if (pushed) k++;
         if (cyc < 12) begin
            line = {line, s1 ? "1" : "0"};
            er = {er, e1 ? "1" : "0"};
         end
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL unsupported cyc%0d: got %b want %b", cyc, obs(), expv());
         end
      end
      char_valid = 1'b0;
      vectors++;
      if (line != "000010111000" || er != "001000000000") begin
         miscompares++;
         $display("FAIL unsupported_line: got %s/%s want 000010111000/001000000000", line, er);
      end
   endtask

   task automatic test_reset_midchar();
      int   highs;
      logic ok;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         char_valid = (cyc == 0);
         char_in = "I";
         step();
         char_valid = 1'b0;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL midchar_I cyc%0d: got %b want %b", cyc, obs(), expv());
         end
      end
      vectors++;
      if (s3 !== 1'b1) begin
         miscompares++;
         $display("FAIL midchar_second_dot: got %b want 1", s3);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({s3, d3, e3, b3, r3} !== 5'b00001) begin
         miscompares++;
         $display("FAIL midchar_async: got %b want 00001", {s3, d3, e3, b3, r3});
      end
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL midchar_in_reset cyc%0d: got %b want %b", i, obs(), expv());
         end
      end
      reset_n = 1'b1;
      highs = 0;
      ok = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         char_valid = (cyc == 0);
         char_in = "T";
         step();
         char_valid = 1'b0;
         if (s3) highs++;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL midchar_T cyc%0d: got %b want %b", cyc, obs(), expv());
         end
         if (cyc > 0 && model_idle()) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok || highs != 9) begin
         miscompares++;
         $display("FAIL midchar_T_highs: got %0d drained=%b want 9 1", highs, ok);
      end
   endtask

   task automatic test_random(input int n_chars, input string tag);
      logic [7:0] bad_set [4];
      int         k;
      int         r;
      logic       ok;
      bad_set = '{8'h23, 8'h31, 8'h2E, 8'h3F};
      k = 0;
      ok = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         char_valid = 1'b0;
         if (k < n_chars && $urandom_range(0, 2) != 0) begin
            char_valid = 1'b1;
            r = $urandom_range(0, 9);
            if (r <= 5)      char_in = 8'(8'h41 + $urandom_range(0, 25));
            else if (r <= 7) char_in = 8'(8'h61 + $urandom_range(0, 25));
            else if (r == 8) char_in = 8'h20;
            else             char_in = bad_set[$urandom_range(0, 3)];
         end
         step();
         if (pushed) k++;
         vectors++;
         if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL random_%s cyc%0d chr=%h: got %b want %b", tag, cyc, char_in, obs(), expv());
         end
         if (k == n_chars && model_idle()) begin
            ok = 1'b1;
            break;
         end
      end
      char_valid = 1'b0;
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL random_%s_timeout: pushed %0d want %0d and drained", tag, k, n_chars);
      end
   endtask

   initial begin
      sel_unit = 1;
      test_reset();
      test_latency();
      test_word_gap();
      test_fifo_full();
      test_unsupported();
      test_random(40, "u1");
      sel_unit = 3;
      test_reset_midchar();
      test_random(12, "u3");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
